// File: rtl/regs_wb_arbiter_pkg.sv
// Shared widths and requester encoding for the register-file writeback arbiter.
// Also used by any other block that arbitrates a shared port.
package regs_wb_arbiter_pkg;
  localparam int XLEN_WIDTH = 32;
  localparam int REG_ADDR   = 5;
  localparam int REG_COUNT  = 1 << REG_ADDR;
  localparam int IDX_W      = 3;

  typedef logic [IDX_W-1:0] req_idx_t;

  typedef enum logic [IDX_W-1:0] {
    REQ_ALU = 3'd0,
    REQ_LSU = 3'd1,
    REQ_MDU = 3'd2
  } req_id_e;
endpackage

// File: rtl/regs_wb_arbiter_rr_arbiter.sv
// Round-robin picker: one-hot grant and index of the first request at or after ptr.
// The request vector is rotated so that the search always starts at bit 0.
module regs_wb_arbiter_rr_arbiter
  import regs_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           ptr,
  output logic [NUM_REQ-1:0] grant,
  output req_idx_t           idx,
  output logic               any
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic                 found;
  int                   off;
  int                   sum;

  always_comb begin
    dbl   = {req, req};
    rot   = NUM_REQ'(dbl >> ptr);
    found = 1'b0;
    off   = 0;
    // Descending scan leaves the lowest rotated position, i.e. the nearest to ptr.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = i;
      end
    end
    sum = int'(ptr) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    any   = found && en;
    idx   = any ? req_idx_t'(sum) : '0;
    grant = any ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/regs_wb_arbiter.sv
// Shares the register file write port among NUM_REQ writeback sources through a
// one-deep registered write slot, with read bypass and a contention counter.
module regs_wb_arbiter
  import regs_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = XLEN_WIDTH,
  parameter int ADDR_W  = REG_ADDR,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*XLEN-1:0]   req_data,
  output logic                      write_en,
  output logic [ADDR_W-1:0]         write_addr,
  output logic [XLEN-1:0]           write_data,
  output logic [2:0]                grant_id,
  input  logic [ADDR_W-1:0]         byp_addr1,
  input  logic [ADDR_W-1:0]         byp_addr2,
  output logic                      byp_hit1,
  output logic                      byp_hit2,
  output logic [CNT_W-1:0]          conflict_cnt
);

  function automatic logic [3:0] popcount(input logic [NUM_REQ-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NUM_REQ; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  req_idx_t            rr_ptr;
  req_idx_t            gnt_idx;
  logic                gnt_any;
  logic                arb_en;
  logic [ADDR_W-1:0]   sel_addr;
  logic [XLEN-1:0]     sel_data;

  assign arb_en = !stall && !rst;

  regs_wb_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .en    (arb_en),
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (req_ready),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Write slot: handshake cycle -> write_en high next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      write_en     <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      grant_id     <= REQ_ALU;
      rr_ptr       <= '0;
      conflict_cnt <= '0;
    end else begin
      if (gnt_any) begin
        // Writes to x0 complete the handshake but never reach the array.
        write_en   <= (sel_addr != '0);
        write_addr <= sel_addr;
        write_data <= sel_data;
        grant_id   <= gnt_idx;
        rr_ptr     <= (gnt_idx == req_idx_t'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end else begin
        write_en <= 1'b0;
      end
      if (popcount(req_valid) >= 4'd2) conflict_cnt <= sat_inc(conflict_cnt);
    end
  end

  assign byp_hit1 = write_en && (write_addr == byp_addr1) && (byp_addr1 != '0);
  assign byp_hit2 = write_en && (write_addr == byp_addr2) && (byp_addr2 != '0);

endmodule
